// File: rtl/uart_pkg.sv
// Shared definitions for the uart_mmio peripheral: register offsets, CON bit positions,
// and the state encoding used by both serial FSMs.
package uart_pkg;

    localparam logic [31:0] TXD_OFF = 32'h0;
    localparam logic [31:0] RXD_OFF = 32'h4;
    localparam logic [31:0] CON_OFF = 32'h8;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_BUSY  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_DONE  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter for bit timing; tick is high during the last cycle of a loaded
// period, so loading N yields a state lasting exactly N cycles.
module uart_baud_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign tick = (cnt == ONE);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON) on the MEM-stage bus.
// Define UART_MMIO_IRQ_EN for a registered interrupt output; without it irq is tied low.
//
// state | meaning (TX and RX FSMs)
// IDLE  | line idle, waiting for a store (TX) or a falling edge (RX)
// START | start bit (RX: half-bit wait, then glitch check)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (RX: also holds here after a framing error until the line is high)
module uart_mmio #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    import uart_pkg::*;

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(DIV / 2);

    logic [31:0] offset;
    logic        sel_txd, sel_rxd, sel_con;
    logic        unused_wdata;

    logic [7:0]  txd_q, rxd_q;
    logic        tx_ie, rx_ie, rx_valid, tx_done;

    uart_state_e tx_state, tx_state_d;
    logic [2:0]  tx_idx, tx_idx_d;
    logic        tx_load, tx_tick, tx_start, tx_done_set, tx_line_d, tx_busy;

    uart_state_e rx_state, rx_state_d;
    logic [2:0]  rx_idx, rx_idx_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic        rx_s1, rx_s2, rx_prev, rx_fall;
    logic        rx_ferr, rx_ferr_d, rx_load, rx_tick, rx_done_set;
    logic [CNT_W-1:0] rx_load_val;

    assign offset  = Address - BASE_ADDR;
    assign hit     = (offset <= CON_OFF) && (offset[1:0] == 2'b00);
    assign sel_txd = hit && (offset == TXD_OFF);
    assign sel_rxd = hit && (offset == RXD_OFF);
    assign sel_con = hit && (offset == CON_OFF);
    assign unused_wdata = ^Write_data[31:8];

    assign tx_busy  = (tx_state != IDLE);
    assign tx_start = MemWrite && sel_txd && !tx_busy;

    always_comb begin
        Read_data = '0;
        if (sel_txd) begin
            Read_data[7:0] = txd_q;
        end else if (sel_rxd) begin
            Read_data[7:0] = rxd_q;
        end else if (sel_con) begin
            Read_data[CON_TX_IE]    = tx_ie;
            Read_data[CON_RX_IE]    = rx_ie;
            Read_data[CON_TX_BUSY]  = tx_busy;
            Read_data[CON_RX_VALID] = rx_valid;
            Read_data[CON_TX_DONE]  = tx_done;
        end
    end

    // Set wins over clear-on-read when both land on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd_q    <= '0;
            rxd_q    <= '0;
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            if (tx_start) txd_q <= Write_data[7:0];
            if (rx_done_set) rxd_q <= rx_shift;
            if (MemWrite && sel_con) begin
                tx_ie <= Write_data[CON_TX_IE];
                rx_ie <= Write_data[CON_RX_IE];
            end
            if (rx_done_set) rx_valid <= 1'b1;
            else if (MemRead && sel_rxd) rx_valid <= 1'b0;
            if (tx_done_set) tx_done <= 1'b1;
            else if (MemRead && sel_con) tx_done <= 1'b0;
        end
    end

    uart_baud_cnt #(.W(CNT_W)) u_tx_baud (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .load_val (DIV_LD),
        .tick     (tx_tick)
    );

    always_comb begin
        tx_state_d  = tx_state;
        tx_idx_d    = tx_idx;
        tx_load     = 1'b0;
        tx_done_set = 1'b0;
        case (tx_state)
            IDLE: if (tx_start) begin
                tx_state_d = START;
                tx_load    = 1'b1;
            end
            START: if (tx_tick) begin
                tx_state_d = DATA;
                tx_idx_d   = 3'd0;
                tx_load    = 1'b1;
            end
            DATA: if (tx_tick) begin
                tx_load = 1'b1;
                if (tx_idx == 3'd7) tx_state_d = STOP;
                else tx_idx_d = tx_idx + 3'd1;
            end
            STOP: if (tx_tick) begin
                tx_state_d  = IDLE;
                tx_done_set = 1'b1;
            end
            default: tx_state_d = IDLE;
        endcase
        case (tx_state_d)
            START:   tx_line_d = 1'b0;
            DATA:    tx_line_d = txd_q[tx_idx_d];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_idx   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_idx   <= tx_idx_d;
            uart_tx  <= tx_line_d;
        end
    end

    uart_baud_cnt #(.W(CNT_W)) u_rx_baud (
        .clk      (clk),
        .reset    (reset),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick)
    );

    assign rx_fall = rx_prev && !rx_s2;

    always_comb begin
        rx_state_d  = rx_state;
        rx_idx_d    = rx_idx;
        rx_shift_d  = rx_shift;
        rx_ferr_d   = rx_ferr;
        rx_load     = 1'b0;
        rx_load_val = DIV_LD;
        rx_done_set = 1'b0;
        case (rx_state)
            IDLE: if (rx_fall) begin
                rx_state_d  = START;
                rx_load     = 1'b1;
                rx_load_val = HALF_LD;
            end
            START: if (rx_tick) begin
                if (rx_s2) begin
                    rx_state_d = IDLE;
                end else begin
                    rx_state_d = DATA;
                    rx_idx_d   = 3'd0;
                    rx_load    = 1'b1;
                end
            end
            DATA: if (rx_tick) begin
                rx_shift_d = {rx_s2, rx_shift[7:1]};
                rx_load    = 1'b1;
                if (rx_idx == 3'd7) rx_state_d = STOP;
                else rx_idx_d = rx_idx + 3'd1;
            end
            STOP: begin
                if (rx_ferr) begin
                    if (rx_s2) begin
                        rx_state_d = IDLE;
                        rx_ferr_d  = 1'b0;
                    end
                end else if (rx_tick) begin
                    if (rx_s2) begin
                        rx_state_d  = IDLE;
                        rx_done_set = 1'b1;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_d;
            rx_idx   <= rx_idx_d;
            rx_shift <= rx_shift_d;
            rx_ferr  <= rx_ferr_d;
        end
    end

`ifdef UART_MMIO_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else irq <= (tx_ie && tx_done) || (rx_ie && rx_valid);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio at DIV=10: bus reads and decoded TX frames are checked
// against expectations queued by the stimulus process.
module tb_uart_mmio;

    localparam int DIV = 10;
    localparam logic [31:0] BASE  = 32'h40000018;
    localparam logic [31:0] TXD_A = BASE;
    localparam logic [31:0] RXD_A = BASE + 32'd4;
    localparam logic [31:0] CON_A = BASE + 32'd8;
`ifdef UART_MMIO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Read_data;
    logic        hit;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;
    bit tx_mon_en = 1'b1;

    logic [31:0] q_data[$];
    bit          q_hit[$];
    string       q_name[$];
    logic [9:0]  q_tx[$];

    logic [31:0] m_d;
    bit          m_h;
    string       m_n;
    logic [9:0]  t_fr, t_e;

    uart_mmio #(.CLK_FREQ(1000000), .BAUD(100000), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Read monitor: every load presented on the bus is checked against the next queued entry.
    always @(negedge clk) begin
        if (MemRead) begin
            n_vec++;
            if (q_data.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: Read_data=%h with no queued expectation", Read_data);
            end else begin
                m_d = q_data.pop_front();
                m_h = q_hit.pop_front();
                m_n = q_name.pop_front();
                if (Read_data !== m_d || hit !== m_h) begin
                    n_bad++;
                    $display("FAIL %s: got data=%h hit=%b, want data=%h hit=%b",
                             m_n, Read_data, hit, m_d, m_h);
                end
            end
        end
    end

    // TX monitor: decode each frame at bit centres; frame = {stop, data[7:0], start}.
    initial begin
        forever begin
            @(negedge uart_tx);
            if (tx_mon_en && reset) begin
                repeat (DIV / 2) @(posedge clk);
                #1 t_fr[0] = uart_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (DIV) @(posedge clk);
                    #1 t_fr[i] = uart_tx;
                end
                n_vec++;
                if (q_tx.size() == 0) begin
                    n_bad++;
                    $display("FAIL tx_unexpected: frame=%b with none queued", t_fr);
                end else begin
                    t_e = q_tx.pop_front();
                    if (t_fr !== t_e) begin
                        n_bad++;
                        $display("FAIL tx_frame: got %b, want %b", t_fr, t_e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input bit h, input string nm);
        q_data.push_back(e);
        q_hit.push_back(h);
        q_name.push_back(nm);
        Address = a;
        MemRead = 1'b1;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        Address = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        Address  = '0;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(DIV);
        end
        uart_rx = stop_bit;
        idle(DIV);
    endtask

    initial begin
        idle(3);
        chk("tx_idle_in_rst", uart_tx, 1'b1);
        chk("irq_in_rst", irq, 1'b0);
        reset = 1'b1;
        idle(2);
        rd(TXD_A, 32'h0, 1'b1, "txd_rst");
        rd(RXD_A, 32'h0, 1'b1, "rxd_rst");
        rd(CON_A, 32'h0, 1'b1, "con_rst");
        rd(BASE + 32'd12, 32'h0, 1'b0, "miss_above");
        rd(BASE + 32'd2, 32'h0, 1'b0, "miss_unaligned");
        rd(BASE - 32'd4, 32'h0, 1'b0, "miss_below");

        // Reset during a frame: line is low (data bit 1 of 0x55) when reset hits.
        tx_mon_en = 1'b0;
        wr(TXD_A, 32'h55);
        idle(24);
        reset = 1'b0;
        #1 chk("tx_high_in_rst", uart_tx, 1'b1);
        idle(3);
        reset = 1'b1;
        idle(1);
        tx_mon_en = 1'b1;
        rd(CON_A, 32'h0, 1'b1, "busy_after_rst");
        rd(TXD_A, 32'h0, 1'b1, "txd_after_rst");

        // 0xA5 frame; store edge is E0, busy through E100, done visible from E101.
        q_tx.push_back({1'b1, 8'hA5, 1'b0});
        wr(TXD_A, 32'hA5);
        rd(CON_A, 32'h04, 1'b1, "busy_e1");
        idle(97);
        rd(CON_A, 32'h04, 1'b1, "busy_e99");
        rd(CON_A, 32'h04, 1'b1, "busy_e100");
        rd(CON_A, 32'h10, 1'b1, "done_set");
        rd(CON_A, 32'h00, 1'b1, "done_clr");
        rd(TXD_A, 32'hA5, 1'b1, "txd_readback");

        // Store while busy is dropped; store one cycle after IDLE returns is accepted.
        q_tx.push_back({1'b1, 8'h3C, 1'b0});
        wr(TXD_A, 32'h3C);
        idle(20);
        wr(TXD_A, 32'h99);
        rd(TXD_A, 32'h3C, 1'b1, "txd_busy_drop");
        idle(78);
        q_tx.push_back({1'b1, 8'h0F, 1'b0});
        wr(TXD_A, 32'h0F);
        idle(105);
        rd(CON_A, 32'h10, 1'b1, "b2b_done");

        wr(CON_A, 32'hFF);
        rd(CON_A, 32'h03, 1'b1, "con_wmask");
        wr(RXD_A, 32'hFF);
        rd(RXD_A, 32'h00, 1'b1, "rxd_ro");
        wr(CON_A, 32'h0);

        send_rx(8'h3C, 1'b1);
        rd(CON_A, 32'h08, 1'b1, "rx_valid");
        rd(RXD_A, 32'h3C, 1'b1, "rxd_3c");
        rd(CON_A, 32'h00, 1'b1, "rx_valid_clr");

        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(30);
        rd(CON_A, 32'h00, 1'b1, "glitch_no_flag");

        send_rx(8'hC3, 1'b0);
        idle(DIV);
        uart_rx = 1'b1;
        idle(20);
        rd(CON_A, 32'h00, 1'b1, "ferr_no_flag");
        rd(RXD_A, 32'h3C, 1'b1, "ferr_rxd_kept");

        // Frame completes on edge E98 after the start edge (2 sync + edge detect + 5 + 80 + 10).
        fork
            send_rx(8'h96, 1'b1);
            begin
                idle(96);
                rd(CON_A, 32'h00, 1'b1, "coll_pre_e97");
                rd(RXD_A, 32'h3C, 1'b1, "coll_old_e98");
            end
        join
        rd(CON_A, 32'h08, 1'b1, "coll_valid_kept");
        rd(RXD_A, 32'h96, 1'b1, "coll_new");
        rd(CON_A, 32'h00, 1'b1, "coll_clr");

        wr(CON_A, 32'h2);
        rd(CON_A, 32'h02, 1'b1, "rx_ie_rb");
        fork
            send_rx(8'h81, 1'b1);
            begin
                idle(98);
                chk("irq_lag_e98", irq, 1'b0);
                idle(1);
                chk("irq_set_e99", irq, IRQ_ON);
            end
        join
        chk("irq_hold", irq, IRQ_ON);
        rd(RXD_A, 32'h81, 1'b1, "rxd_81");
        idle(1);
        chk("irq_clr", irq, 1'b0);
        rd(CON_A, 32'h02, 1'b1, "con_after_irq");

        idle(20);
        n_vec++;
        if (q_tx.size() != 0) begin
            n_bad++;
            $display("FAIL tx_missing: %0d frames not seen, want 0", q_tx.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
